// File: rtl/button_event_decoder.sv
// Classifies debounced button activity into one-cycle click, double-click and
// long-press pulses per channel, plus a registered active-high pressed level.
module button_event_decoder #(
   parameter int    WIDTH     = 2,
   parameter string POLARITY  = "LOW",
   parameter int    LONG_TIME = 50000000,
   parameter int    GAP_TIME  = 12500000,
   parameter int    CNT_WIDTH = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] pressed,
   output logic [WIDTH-1:0] click,
   output logic [WIDTH-1:0] double_click,
   output logic [WIDTH-1:0] long_press
);

   localparam bit                 ACTIVE_LOW = (POLARITY == "LOW");
   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_TIME - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_TIME - 1);

   typedef enum logic [2:0] {
      IDLE,
      DOWN1,
      WAIT2,
      DOWN2,
      HELD
   } state_t;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_ch
         state_t               state_reg;
         logic [CNT_WIDTH-1:0] cnt_reg;
         logic                 p_reg;
         logic                 p_d_reg;
         logic                 armed_reg;
         logic                 click_reg;
         logic                 double_reg;
         logic                 long_reg;
         logic                 p_in;
         logic                 press_edge;
         logic                 release_edge;

         assign p_in         = ACTIVE_LOW ? ~data_in[gi] : data_in[gi];
         assign press_edge   = p_reg & ~p_d_reg;
         assign release_edge = ~p_reg & p_d_reg;

         assign pressed[gi]      = p_reg;
         assign click[gi]        = click_reg;
         assign double_click[gi] = double_reg;
         assign long_press[gi]   = long_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg  <= IDLE;
               cnt_reg    <= '0;
               p_reg      <= 1'b0;
               p_d_reg    <= 1'b0;
               armed_reg  <= 1'b0;
               click_reg  <= 1'b0;
               double_reg <= 1'b0;
               long_reg   <= 1'b0;
            end else begin
               p_reg      <= p_in;
               p_d_reg    <= p_reg;
               // Arm together with the first released sample loaded into p, so
               // a button held through reset never yields a press edge.
               armed_reg  <= armed_reg | ~p_in;
               click_reg  <= 1'b0;
               double_reg <= 1'b0;
               long_reg   <= 1'b0;

               case (state_reg)
                  IDLE: begin
                     cnt_reg <= '0;
                     if (press_edge && armed_reg) begin
                        state_reg <= DOWN1;
                     end
                  end
                  DOWN1: begin
                     // Release is tested first so it wins on the terminal cycle.
                     if (release_edge) begin
                        state_reg <= WAIT2;
                        cnt_reg   <= '0;
                     end else if (cnt_reg == LONG_LAST) begin
                        long_reg  <= 1'b1;
                        state_reg <= HELD;
                        cnt_reg   <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
                  WAIT2: begin
                     if (press_edge) begin
                        state_reg <= DOWN2;
                        cnt_reg   <= '0;
                     end else if (cnt_reg == GAP_LAST) begin
                        click_reg <= 1'b1;
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
                  DOWN2: begin
                     if (release_edge) begin
                        double_reg <= 1'b1;
                        state_reg  <= IDLE;
                        cnt_reg    <= '0;
                     end else if (cnt_reg == LONG_LAST) begin
                        long_reg  <= 1'b1;
                        state_reg <= HELD;
                        cnt_reg   <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
                  HELD: begin
                     cnt_reg <= '0;
                     if (release_edge) begin
                        state_reg <= IDLE;
                     end
                  end
                  default: begin
                     state_reg <= IDLE;
                     cnt_reg   <= '0;
                  end
               endcase
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: stimulus queues expected pulses
// with their cycle numbers, a negedge monitor pops and compares them.
module tb_button_event_decoder;

   localparam int LONG_TIME = 20;
   localparam int GAP_TIME  = 8;
   localparam int EV_NONE   = 0;
   localparam int EV_CLICK  = 1;
   localparam int EV_DOUBLE = 2;
   localparam int EV_LONG   = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] data_in = 2'b01;
   logic [1:0] pressed;
   logic [1:0] click;
   logic [1:0] double_click;
   logic [1:0] long_press;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [1:0] exp_pressed = 2'b00;

   typedef struct {
      int kind;
      int at;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   button_event_decoder #(
      .WIDTH    (2),
      .POLARITY ("LOW"),
      .LONG_TIME(LONG_TIME),
      .GAP_TIME (GAP_TIME),
      .CNT_WIDTH(26)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data_in     (data_in),
      .pressed     (pressed),
      .click       (click),
      .double_click(double_click),
      .long_press  (long_press)
   );

   always #5 clk = ~clk;

   // Reference level: active-low input inverted, one clock late, cleared by reset.
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      exp_pressed <= reset ? 2'b00 : ~data_in;
   end

   function automatic string kname(input int k);
      case (k)
         EV_CLICK:  return "click";
         EV_DOUBLE: return "double_click";
         EV_LONG:   return "long_press";
         default:   return "none";
      endcase
   endfunction

   task automatic push(input int ch, input int kind, input int at);
      exp_t e;
      e.kind = kind;
      e.at   = at;
      if (ch == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic score(input int ch, input int obs);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (ch == 0 && q0.size() > 0) begin
         e = q0[0];
         have = 1'b1;
      end else if (ch == 1 && q1.size() > 0) begin
         e = q1[0];
         have = 1'b1;
      end
      if (have && e.at < cyc) begin
         checks++;
         errors++;
         $display("FAIL missed_ch%0d: got none, required %s at cycle %0d (now %0d)",
                  ch, kname(e.kind), e.at, cyc);
         if (ch == 0) void'(q0.pop_front());
         else void'(q1.pop_front());
         have = 1'b0;
      end
      if (have && e.at == cyc) begin
         checks++;
         if (obs != e.kind) begin
            errors++;
            $display("FAIL event_ch%0d cycle %0d: got %s, required %s",
                     ch, cyc, kname(obs), kname(e.kind));
         end else begin
            $display("ok   event_ch%0d cycle %0d: %s", ch, cyc, kname(obs));
         end
         if (ch == 0) void'(q0.pop_front());
         else void'(q1.pop_front());
      end else if (obs != EV_NONE) begin
         checks++;
         errors++;
         $display("FAIL unexpected_ch%0d cycle %0d: got %s, required none",
                  ch, cyc, kname(obs));
      end
   endtask

   always @(negedge clk) begin
      int n;
      int obs;
      if (cyc > 0) begin
         for (int ch = 0; ch < 2; ch++) begin
            n = int'(click[ch]) + int'(double_click[ch]) + int'(long_press[ch]);
            checks++;
            if (n > 1) begin
               errors++;
               $display("FAIL exclusive_ch%0d cycle %0d: got %0d pulses, required at most 1",
                        ch, cyc, n);
            end
            obs = long_press[ch] ? EV_LONG : double_click[ch] ? EV_DOUBLE :
                  click[ch] ? EV_CLICK : EV_NONE;
            score(ch, obs);
            checks++;
            if (pressed[ch] !== exp_pressed[ch]) begin
               errors++;
               $display("FAIL pressed_ch%0d cycle %0d: got %b, required %b",
                        ch, cyc, pressed[ch], exp_pressed[ch]);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int ch, input bit down);
      data_in[ch] = ~down;
   endtask

   // Press for 'low' clocks, then release for 'high' clocks.
   task automatic tap(input int ch, input int low, input int high);
      set_btn(ch, 1'b1);
      tick(low);
      set_btn(ch, 1'b0);
      tick(high);
   endtask

   initial begin
      int t;
      // ch1 pressed through reset: held level must not arm the channel.
      tick(3);
      reset = 1'b0;
      tick(12);
      set_btn(1, 1'b0);
      tick(5);
      t = cyc;
      push(1, EV_CLICK, t + 5 + 2 + GAP_TIME);
      tap(1, 5, 20);

      // Single tap
      t = cyc;
      push(0, EV_CLICK, t + 5 + 2 + GAP_TIME);
      tap(0, 5, 20);

      // Double tap: second release at t+13
      t = cyc;
      push(0, EV_DOUBLE, t + 15);
      tap(0, 5, 3);
      tap(0, 5, 20);

      // Long hold, silent release
      t = cyc;
      push(0, EV_LONG, t + 2 + LONG_TIME);
      tap(0, 40, 20);

      // Release on DOWN1 terminal cycle: click, no long_press
      t = cyc;
      push(0, EV_CLICK, t + LONG_TIME + 2 + GAP_TIME);
      tap(0, LONG_TIME, 20);

      // One clock longer: long_press wins
      t = cyc;
      push(0, EV_LONG, t + 2 + LONG_TIME);
      tap(0, LONG_TIME + 1, 20);

      // Press on WAIT2 terminal cycle: double_click, no click
      t = cyc;
      push(0, EV_DOUBLE, t + 20);
      tap(0, 5, GAP_TIME);
      tap(0, 5, 20);

      // Press one clock after the gap: click, then a fresh sequence
      t = cyc;
      push(0, EV_CLICK, t + 15);
      push(0, EV_CLICK, t + 29);
      tap(0, 5, GAP_TIME + 1);
      tap(0, 5, 25);

      // Second press held long: long_press, first click discarded
      t = cyc;
      push(0, EV_LONG, t + 8 + 2 + LONG_TIME);
      tap(0, 5, 3);
      tap(0, 25, 20);

      // Triple press: double_click then a new single click
      t = cyc;
      push(0, EV_DOUBLE, t + 11);
      push(0, EV_CLICK, t + 25);
      tap(0, 3, 3);
      tap(0, 3, 3);
      tap(0, 3, 20);

      // Reset mid-DOWN1 aborts silently
      set_btn(0, 1'b1);
      tick(8);
      reset = 1'b1;
      tick(1);
      checks++;
      if ({pressed, click, double_click, long_press} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 00000000",
                  {pressed, click, double_click, long_press});
      end else begin
         $display("ok   reset_outputs cycle %0d: all zero", cyc);
      end
      reset = 1'b0;
      tick(5);
      set_btn(0, 1'b0);
      tick(30);

      // Independence: ch0 long hold alongside ch1 double tap
      t = cyc;
      push(0, EV_LONG, t + 2 + LONG_TIME);
      push(1, EV_DOUBLE, t + 15);
      fork
         tap(0, 40, 5);
         begin
            tap(1, 5, 3);
            tap(1, 5, 27);
         end
      join
      tick(10);

      checks++;
      if (q0.size() != 0) begin
         errors++;
         $display("FAIL leftover_ch0: got %0d pending events, required 0", q0.size());
      end
      checks++;
      if (q1.size() != 0) begin
         errors++;
         $display("FAIL leftover_ch1: got %0d pending events, required 0", q1.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, required finish before 100us");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the key debouncer. It consumes the debounced, still-polarity-encoded button vector and classifies each channel's activity into one-cycle event pulses: click, double click and long press.
- It also provides a normalized active-high pressed level.
- The events feed HPS reset-request and user-control logic, so software and reset paths see clean, single-cycle intents instead of raw levels.
- Channels are fully independent.

Parameters:
- WIDTH, 2, number of button channels.
- POLARITY, "LOW", pressed level of data_in; "LOW" means 0 = pressed, "HIGH" means 1 = pressed.
- LONG_TIME, 50000000, clocks a press must be held to become a long press (1 s at 50 MHz); must be ≥2.
- GAP_TIME, 12500000, clocks after a release during which a second press makes a double click (250 ms at 50 MHz); must be ≥2.
- CNT_WIDTH, 26, per-channel counter width; must hold max(LONG_TIME, GAP_TIME)-1.

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, synchronous active-high reset.
- data_in, input, WIDTH, debounced button levels, encoded per POLARITY.
- pressed, output, WIDTH, registered normalized level (1 = pressed).
- click, output, WIDTH, one-cycle pulse per single short press.
- double_click, output, WIDTH, one-cycle pulse per double short press.
- long_press, output, WIDTH, one-cycle pulse when a hold reaches LONG_TIME.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset:
  - All outputs are 0; all channel states are IDLE; counters are 0; armed is 0.
  - Reset asserted mid-operation aborts any sequence, with no pulse emitted.
- Input stage, per channel i:
  - p[i] <= normalized data_in[i] (inverted when POLARITY="LOW"); p_d[i] <= p[i]; pressed[i] = p[i].
  - press edge = p & ~p_d. Release edge = ~p & p_d.
- Arming: after reset, a channel sets armed when p is first observed as 0. Press edges are ignored while armed is 0, so a button held through reset produces no events.
- Per-channel FSM (states IDLE, DOWN1, WAIT2, DOWN2, HELD):
  - The counter clears on every state entry and increments by 1 each cycle in DOWN1, WAIT2 and DOWN2.
  - IDLE: on an armed press edge, go to DOWN1.
  - DOWN1, release edge: go to WAIT2.
  - DOWN1, count == LONG_TIME-1 and still pressed: assert long_press and go to HELD.
  - DOWN1 tie rule: a release on the terminal cycle wins, giving WAIT2 and no long_press.
  - WAIT2, press edge: go to DOWN2.
  - WAIT2, count == GAP_TIME-1 with no press: assert click and go to IDLE.
  - WAIT2 tie rule: a press on the terminal cycle wins, giving DOWN2 and no click.
  - DOWN2, release edge: assert double_click and go to IDLE.
  - DOWN2, count == LONG_TIME-1 and still pressed: assert long_press and go to HELD. The pending first click is discarded.
  - DOWN2 tie rule: release wins.
  - HELD: on release edge, go to IDLE with no pulse.
- Timing:
  - Latency from a data_in change to p is 1 clk. The transition happens on the following edge.
  - Pulses are registered on the same edge as the state transition and are high for exactly 1 cycle.
  - long_press is high in the cycle starting LONG_TIME clocks after the edge that entered DOWN1/DOWN2.
  - click is high in the cycle starting GAP_TIME clocks after WAIT2 entry.
- Exclusivity: at most one of click, double_click or long_press pulses per channel per cycle. Exactly one event is produced per completed sequence, except HELD release, which produces none.
- Triple press: the third press is seen in IDLE after the double_click and starts a new sequence.
- Counters saturate by construction, because every counting state exits at its terminal count. No wrap-around is possible.

Test Plan (WIDTH=2, POLARITY="LOW", LONG_TIME=20, GAP_TIME=8):
- Single tap: ch0 low for 5 clks, then high → click[0] pulses exactly 1 cycle, 8 clks after WAIT2 entry; no double_click or long_press; pressed[0] mirrors input with 1-clk delay.
- Double tap: ch0 low 5, high 3, low 5, high → double_click[0] one pulse 2 clks after the second rising data_in; click[0] never asserts.
- Long hold: ch0 low 40 clks → long_press[0] one pulse 20 clks after DOWN1 entry; no pulse on release.
- Tie cases:
  - Release exactly on DOWN1 terminal cycle → click later, no long_press.
  - Press exactly on WAIT2 terminal cycle → DOWN2, and release gives double_click, no click.
- Reset:
  - ch1 held low through reset deassertion → no events until released; the next tap gives a click.
  - reset pulse mid-DOWN1 → all outputs 0 next cycle, no late pulses.
- Independence: ch0 long hold concurrent with ch1 double tap → long_press[0] and double_click[1] each appear once, at their independent timings.
